paddle_array_ctrl: RTL and testbench
====================================

Name: paddle_array_ctrl

Overview:
- Per-player paddle position controllers for N players in one block, feeding the pong renderer and collision logic.
- Each channel moves its paddle one step per press, with optional hold-to-repeat timed by an external slow tick.
- Each channel has parametrised bounds and reloads to its start position while disabled.
- A held or conflicting button never causes a spurious move.

Parameters:
- NUM_PLAYERS, 2, number of independent paddle channels.
- BIT_WIDTH, 4, width of each position value.
- SIZE, 4, paddle length in cells. MAX_POS = 2^BIT_WIDTH-1-SIZE (11 at defaults).
- MIN_POS, 1, lowest legal position.
- START, 7, reload position is START-1. Elaboration error if START-1 is outside [MIN_POS, MAX_POS].
- REPEAT_DELAY, 4, ticks a button must be held before auto-repeat begins. 0 disables auto-repeat.
- REPEAT_RATE, 2, ticks between auto-repeat steps. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  game running. When low, all channels reload.
- tick  in  1  one-cycle slow timebase strobe used for repeat timing.
- btn_left  in  NUM_PLAYERS  bit i = player i left button, already synchronised.
- btn_right  in  NUM_PLAYERS  bit i = player i right button.
- pos  out  NUM_PLAYERS*BIT_WIDTH  player i position at [i*BIT_WIDTH +: BIT_WIDTH], registered.
- moved  out  NUM_PLAYERS  one-cycle pulse, registered, asserted on the cycle pos[i] changes.
- at_min  out  NUM_PLAYERS  combinational, pos[i]==MIN_POS.
- at_max  out  NUM_PLAYERS  combinational, pos[i]==MAX_POS.

Behaviour:
- Reset: every pos = START-1, every channel state = IDLE, repeat counters = 0, moved = 0. rst overrides en and all buttons.
- Input decode per channel: dir = {btn_left, btn_right}. 10 = left, 01 = right, 00 = released, 11 = conflict.
- Moves:
  - Left: pos-1, blocked at MIN_POS. Right: pos+1, blocked at MAX_POS.
  - A blocked move leaves pos unchanged, moved stays 0, and state transitions proceed as if the move happened.
- Latency: buttons sampled at edge k → pos and moved valid after edge k (one register stage). No combinational path from buttons to outputs.
- en low, checked every cycle and overriding the FSM:
  - pos = START-1 and counter = 0.
  - State = LOCK if dir≠00, else IDLE.
  - moved = 1 only if pos actually changed on the reload.
  - A button held across the en rising edge therefore causes no move until it is released.
- Channel FSM (en high):
  - IDLE:
    - dir=10 or 01 → step once, counter = 0, go to HOLD.
    - dir=11 → go to LOCK.
    - dir=00 → stay.
  - HOLD:
    - dir=00 → IDLE.
    - dir differs from the direction that entered HOLD → LOCK.
    - Otherwise, on tick, counter++.
    - On the tick where the counter reaches REPEAT_DELAY-1 → step, counter = 0, go to REPEAT.
    - If REPEAT_DELAY=0, never leave HOLD except on release or change. This gives single-step per press.
  - REPEAT:
    - dir=00 → IDLE.
    - dir change → LOCK.
    - Otherwise, on tick, counter++.
    - On the tick where the counter reaches REPEAT_RATE-1 → step, counter = 0.
  - LOCK: no movement; dir=00 → IDLE.
- Release and tick in the same cycle: release wins, no step.
- Channels are fully independent; simultaneous moves on all channels are legal.
- Counter width is clog2(max(REPEAT_DELAY, REPEAT_RATE, 2)). The counter never wraps because it is cleared on terminal count.
- Reset mid-hold: the next cycle is IDLE. A still-held button then moves immediately; the reset case is not locked like the en case.

Decomposition:
- Package pong_pkg holds:
  - channel state enum: IDLE, HOLD, REPEAT, LOCK (2-bit);
  - dir encoding constants DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_BOTH;
  - function max_pos(BIT_WIDTH, SIZE).
- Sub-module paddle_channel contains one FSM, its counter and its position register. Top instantiates NUM_PLAYERS copies in a generate loop and packs the outputs.

Test Plan:
- Reset then en=1, no buttons → pos = {6,6}, moved = 00, at_min = at_max = 00.
- P0 left pulse (1 cycle, then release), tick held low → pos0 = 5, moved[0] pulses exactly once. A second pulse → pos0 = 4. pos1 stays 6 throughout.
- P1 holds right with tick every cycle (REPEAT_DELAY=4, REPEAT_RATE=2):
  - pos1 sequence 6 → 7 at the press;
  - 8 on the 4th tick;
  - then +1 every 2 ticks;
  - saturates at 11 with at_max[1]=1 and no further moved pulses.
- P0 at 1 presses left → pos0 stays 1, moved[0]=0. Then left+right together → no move (LOCK). Release, then right → pos0 = 2.
- en=0 with P0 holding left → pos0 = 6 reload. en=1 with left still held → no move. Release, then press left → 5.
- Direction swap: hold left into REPEAT, switch to right without releasing → no movement until both are released. Then a right press gives +1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong paddle controllers.
// Channel FSM states, button direction encodings and the paddle travel limit.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } chan_state_t;

  // dir = {btn_left, btn_right}
  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_BOTH  = 2'b11;

  function automatic int max_pos(input int bit_width, input int size);
    return (1 << bit_width) - 1 - size;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: press-to-step with tick-timed auto-repeat, bounded position, reload while disabled.
// Latency 1 cycle from buttons to pos/moved; no backpressure, buttons are sampled every cycle.
module paddle_channel
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH    = 4,
  parameter int SIZE         = 4,
  parameter int MIN_POS      = 1,
  parameter int START        = 7,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 btn_left,
  input  logic                 btn_right,
  output logic [BIT_WIDTH-1:0] pos,
  output logic                 moved
);

  localparam int MAX_P    = max_pos(BIT_WIDTH, SIZE);
  localparam int SPAN_DR  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_SPAN = (SPAN_DR > 2) ? SPAN_DR : 2;
  localparam int CW       = $clog2(CNT_SPAN);

  localparam logic [BIT_WIDTH-1:0] POS_MIN   = BIT_WIDTH'(MIN_POS);
  localparam logic [BIT_WIDTH-1:0] POS_MAX   = BIT_WIDTH'(MAX_P);
  localparam logic [BIT_WIDTH-1:0] POS_START = BIT_WIDTH'(START - 1);
  localparam logic [CW-1:0]        DELAY_TC  = CW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CW-1:0]        RATE_TC   = CW'(REPEAT_RATE - 1);

  chan_state_t          state;
  logic [1:0]           dir;
  logic [1:0]           hold_dir;
  logic [CW-1:0]        cnt;
  logic [BIT_WIDTH-1:0] step_pos;
  logic                 step_ok;

  assign dir = {btn_left, btn_right};

  // Candidate step for the current direction; a blocked step keeps pos and reports no move.
  always_comb begin
    step_pos = pos;
    step_ok  = 1'b0;
    if (dir == DIR_LEFT && pos > POS_MIN) begin
      step_pos = pos - 1'b1;
      step_ok  = 1'b1;
    end else if (dir == DIR_RIGHT && pos < POS_MAX) begin
      step_pos = pos + 1'b1;
      step_ok  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= POS_START;
      cnt      <= '0;
      hold_dir <= DIR_NONE;
      moved    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (!en) begin
        // Anything held across enable stays locked until released.
        pos   <= POS_START;
        cnt   <= '0;
        state <= (dir != DIR_NONE) ? LOCK : IDLE;
        moved <= (pos != POS_START);
      end else begin
        case (state)
          IDLE: begin
            case (dir)
              DIR_LEFT, DIR_RIGHT: begin
                pos      <= step_pos;
                moved    <= step_ok;
                cnt      <= '0;
                hold_dir <= dir;
                state    <= HOLD;
              end
              DIR_BOTH: state <= LOCK;
              default:  state <= IDLE;
            endcase
          end
          HOLD: begin
            if (dir == DIR_NONE) begin
              state <= IDLE;
            end else if (dir != hold_dir) begin
              state <= LOCK;
            end else if (tick && REPEAT_DELAY != 0) begin
              if (cnt == DELAY_TC) begin
                pos   <= step_pos;
                moved <= step_ok;
                cnt   <= '0;
                state <= REPEAT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (dir == DIR_NONE) begin
              state <= IDLE;
            end else if (dir != hold_dir) begin
              state <= LOCK;
            end else if (tick) begin
              if (cnt == RATE_TC) begin
                pos   <= step_pos;
                moved <= step_ok;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
            if (dir == DIR_NONE) state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/paddle_array_ctrl.sv
// N independent paddle channels with packed position outputs and bound flags.
// Latency 1 cycle for pos/moved, at_min/at_max follow pos combinationally; no backpressure.
module paddle_array_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int BIT_WIDTH    = 4,
  parameter int SIZE         = 4,
  parameter int MIN_POS      = 1,
  parameter int START        = 7,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             tick,
  input  logic [NUM_PLAYERS-1:0]           btn_left,
  input  logic [NUM_PLAYERS-1:0]           btn_right,
  output logic [NUM_PLAYERS*BIT_WIDTH-1:0] pos,
  output logic [NUM_PLAYERS-1:0]           moved,
  output logic [NUM_PLAYERS-1:0]           at_min,
  output logic [NUM_PLAYERS-1:0]           at_max
);

  localparam int MAX_P = max_pos(BIT_WIDTH, SIZE);
  localparam logic [BIT_WIDTH-1:0] POS_MIN = BIT_WIDTH'(MIN_POS);
  localparam logic [BIT_WIDTH-1:0] POS_MAX = BIT_WIDTH'(MAX_P);

  if (START - 1 < MIN_POS || START - 1 > MAX_P) begin : g_bad_start
    $error("paddle_array_ctrl: START-1 outside [MIN_POS, MAX_POS]");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("paddle_array_ctrl: REPEAT_RATE must be at least 1");
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
    paddle_channel #(
      .BIT_WIDTH   (BIT_WIDTH),
      .SIZE        (SIZE),
      .MIN_POS     (MIN_POS),
      .START       (START),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .tick     (tick),
      .btn_left (btn_left[i]),
      .btn_right(btn_right[i]),
      .pos      (pos[i*BIT_WIDTH +: BIT_WIDTH]),
      .moved    (moved[i])
    );
  end

  always_comb begin
    at_min = '0;
    at_max = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      at_min[i] = (pos[i*BIT_WIDTH +: BIT_WIDTH] == POS_MIN);
      at_max[i] = (pos[i*BIT_WIDTH +: BIT_WIDTH] == POS_MAX);
    end
  end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Directed bench: expected moves are queued per player at stimulus time, a negedge monitor
// pops them on every moved pulse and flags unexpected or silent position changes.
module tb_paddle_array_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] btn_left = 2'b00;
  logic [1:0] btn_right = 2'b00;
  logic [7:0] pos;
  logic [1:0] moved;
  logic [1:0] at_min;
  logic [1:0] at_max;

  int n_checks = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];
  logic       rst_seen;
  logic [7:0] prev_pos;

  paddle_array_ctrl #(
    .NUM_PLAYERS(2), .BIT_WIDTH(4), .SIZE(4), .MIN_POS(1),
    .START(7), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right),
    .pos(pos), .moved(moved), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [1:0] l, input logic [1:0] r, input logic tk, input int n);
    btn_left  = l;
    btn_right = r;
    tick      = tk;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every moved pulse must match the next queued position for that player.
  initial begin
    int p;
    forever begin
      @(negedge clk);
      if (rst_seen === 1'b0) begin
        for (int i = 0; i < 2; i++) begin
          p = int'(pos[i*4 +: 4]);
          if (moved[i]) begin
            if (i == 0) begin
              if (q0.size() == 0) chk("p0_spurious_move", p, 32'hFFFF);
              else chk("p0_move_pos", p, q0.pop_front());
            end else begin
              if (q1.size() == 0) chk("p1_spurious_move", p, 32'hFFFF);
              else chk("p1_move_pos", p, q1.pop_front());
            end
          end else if (pos[i*4 +: 4] !== prev_pos[i*4 +: 4]) begin
            chk("silent_pos_change", p, int'(prev_pos[i*4 +: 4]));
          end
        end
      end
      prev_pos = pos;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset_pos", pos, 8'h66);
    chk("reset_moved", moved, 2'b00);
    rst = 1'b0;
    en  = 1'b1;
    apply(2'b00, 2'b00, 1'b0, 2);
    chk("idle_pos", pos, 8'h66);
    chk("idle_moved", moved, 2'b00);
    chk("idle_at_min", at_min, 2'b00);
    chk("idle_at_max", at_max, 2'b00);

    // Single left pulses on player 0
    q0.push_back(5);
    apply(2'b01, 2'b00, 1'b0, 1);
    chk("p0_pulse1_pos", pos[3:0], 5);
    chk("p0_pulse1_moved", moved, 2'b01);
    apply(2'b00, 2'b00, 1'b0, 2);
    chk("p0_pulse1_once", moved, 2'b00);
    q0.push_back(4);
    apply(2'b01, 2'b00, 1'b0, 1);
    apply(2'b00, 2'b00, 1'b0, 1);
    chk("p0_pulse2_pos", pos, 8'h64);

    // Player 1 holds right with tick every cycle: delay 4 ticks, then every 2
    for (int v = 7; v <= 11; v++) q1.push_back(v);
    apply(2'b00, 2'b10, 1'b1, 1);
    chk("p1_press", pos[7:4], 7);
    apply(2'b00, 2'b10, 1'b1, 3);
    chk("p1_delay_wait", pos[7:4], 7);
    apply(2'b00, 2'b10, 1'b1, 1);
    chk("p1_first_repeat", pos[7:4], 8);
    apply(2'b00, 2'b10, 1'b1, 2);
    chk("p1_rate_step", pos[7:4], 9);
    apply(2'b00, 2'b10, 1'b1, 4);
    chk("p1_reach_max", pos[7:4], 11);
    chk("p1_at_max", at_max, 2'b10);
    apply(2'b00, 2'b10, 1'b1, 6);
    chk("p1_saturated", pos[7:4], 11);
    chk("p1_sat_moved", moved, 2'b00);
    apply(2'b00, 2'b00, 1'b0, 1);

    // Player 0 to the lower bound, blocked move, conflict lock
    for (int v = 3; v >= 1; v--) begin
      q0.push_back(v);
      apply(2'b01, 2'b00, 1'b0, 1);
      apply(2'b00, 2'b00, 1'b0, 1);
    end
    chk("p0_at_min_pos", pos[3:0], 1);
    chk("p0_at_min", at_min, 2'b01);
    apply(2'b01, 2'b00, 1'b0, 1);
    chk("p0_blocked_pos", pos[3:0], 1);
    chk("p0_blocked_moved", moved, 2'b00);
    apply(2'b00, 2'b00, 1'b0, 1);
    apply(2'b01, 2'b01, 1'b1, 3);
    chk("p0_conflict", pos[3:0], 1);
    apply(2'b01, 2'b00, 1'b1, 3);
    chk("p0_lock_one_left", pos[3:0], 1);
    apply(2'b00, 2'b00, 1'b0, 1);
    q0.push_back(2);
    apply(2'b00, 2'b01, 1'b0, 1);
    chk("p0_after_lock", pos[3:0], 2);
    apply(2'b00, 2'b00, 1'b0, 1);

    // Disable with a held button reloads; held button locks across enable
    q0.push_back(6);
    q1.push_back(6);
    en = 1'b0;
    apply(2'b01, 2'b00, 1'b0, 1);
    chk("reload_pos", pos, 8'h66);
    chk("reload_moved", moved, 2'b11);
    apply(2'b01, 2'b00, 1'b0, 1);
    chk("reload_no_change", moved, 2'b00);
    en = 1'b1;
    apply(2'b01, 2'b00, 1'b1, 3);
    chk("en_held_locked", pos[3:0], 6);
    apply(2'b00, 2'b00, 1'b0, 1);
    q0.push_back(5);
    apply(2'b01, 2'b00, 1'b0, 1);
    chk("en_after_release", pos[3:0], 5);
    apply(2'b00, 2'b00, 1'b0, 1);

    // Direction swap during repeat locks until full release
    q0.push_back(4);
    q0.push_back(3);
    apply(2'b01, 2'b00, 1'b1, 1);
    chk("swap_press", pos[3:0], 4);
    apply(2'b01, 2'b00, 1'b1, 3);
    chk("swap_delay_wait", pos[3:0], 4);
    apply(2'b01, 2'b00, 1'b1, 1);
    chk("swap_repeat", pos[3:0], 3);
    apply(2'b00, 2'b01, 1'b1, 5);
    chk("swap_locked", pos[3:0], 3);
    apply(2'b00, 2'b00, 1'b0, 1);
    q0.push_back(4);
    apply(2'b00, 2'b01, 1'b0, 1);
    chk("swap_after_release", pos[3:0], 4);
    apply(2'b00, 2'b00, 1'b0, 1);

    // Reset while held: next cycle is IDLE, so the held button moves at once
    q1.push_back(7);
    apply(2'b00, 2'b10, 1'b0, 1);
    chk("rst_hold_press", pos[7:4], 7);
    rst = 1'b1;
    apply(2'b00, 2'b10, 1'b0, 1);
    chk("rst_hold_pos", pos, 8'h66);
    chk("rst_hold_moved", moved, 2'b00);
    rst = 1'b0;
    q1.push_back(7);
    apply(2'b00, 2'b10, 1'b0, 1);
    chk("rst_hold_move", pos[7:4], 7);
    chk("rst_hold_pulse", moved, 2'b10);
    apply(2'b00, 2'b00, 1'b0, 3);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
